blink_pattern_sequencer: RTL

Sequences the `blink_controller` through a programmable table of blink steps, each step a (speed, duration) pair. It drives the controller's `speed` input and holds the controller in reset while idle. It sits between the board-level control logic and the `blink_controller` instance. It owns the millisecond timebase used to measure step durations.

---
 rtl/blink_pattern_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/blink_pattern_sequencer.sv
// Steps a blink_controller through a programmable (speed, duration) table on a millisecond timebase.
// Build option BLINK_SEQ_SIM_FAST_EN forces a 10-cycle millisecond for short simulations.
module blink_pattern_sequencer #(
  parameter int CLK_HZ = 100_000_000,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [15:0]   cfg_speed,
  input  logic [15:0]   cfg_dur,
  input  logic [AW-1:0] last_idx,
  input  logic          loop_en,
  input  logic          start,
  input  logic          stop,
  output logic [15:0]   speed,
  output logic          blink_hold,
  output logic          busy,
  output logic [AW-1:0] step_idx,
  output logic          done
);

  // state | meaning
  // IDLE  | controller held in reset, speed 0, waiting for start
  // LOAD  | one cycle reading table entry step_idx
  // RUN   | step active, counting milliseconds until dur elapses

`ifdef BLINK_SEQ_SIM_FAST_EN
  localparam int TICKS_PER_MS = 10;
`else
  localparam int TICKS_PER_MS = CLK_HZ / 1000;
`endif
  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [31:0]     tbl_q [DEPTH];
  logic [AW-1:0]   step_idx_q, step_idx_d;
  logic [15:0]     speed_q, speed_d;
  logic            hold_q, hold_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [15:0]     dur_q;
  logic [15:0]     ms_q;
  logic [PW-1:0]   presc_q;
  logic [15:0]     ent_speed, ent_dur;
  logic [AW-1:0]   idx_inc;
  logic            tick_wrap, step_end;

  // Entry layout: speed in the upper half, duration in the lower half.
  assign ent_speed = tbl_q[step_idx_q][31:16];
  assign ent_dur   = tbl_q[step_idx_q][15:0];
  assign idx_inc   = (step_idx_q == IDX_LAST) ? '0 : step_idx_q + 1'b1;
  assign tick_wrap = (presc_q == PRESC_LAST);
  assign step_end  = (state_q == S_RUN) && tick_wrap && (ms_q == dur_q - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else if (cfg_we) begin
      tbl_q[cfg_addr] <= {cfg_speed, cfg_dur};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_idx_q <= '0;
      speed_q    <= '0;
      hold_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_idx_q <= step_idx_d;
      speed_q    <= speed_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Step duration is latched at LOAD so live table rewrites only affect later steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      dur_q   <= '0;
      ms_q    <= '0;
      presc_q <= '0;
    end else if (state_q == S_LOAD) begin
      dur_q   <= ent_dur;
      ms_q    <= '0;
      presc_q <= '0;
    end else if (state_q == S_RUN) begin
      if (tick_wrap) begin
        presc_q <= '0;
        ms_q    <= ms_q + 16'd1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    step_idx_d = step_idx_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d    = S_LOAD;
          step_idx_d = '0;
        end
      end
      S_LOAD: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (ent_dur == 16'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (step_end) begin
          if (step_idx_q != last_idx) begin
            state_d    = S_LOAD;
            step_idx_d = idx_inc;
          end else if (loop_en) begin
            state_d    = S_LOAD;
            step_idx_d = '0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Speed and hold keep their values through LOAD so the LED does not glitch between steps.
  always_comb begin
    speed_d = speed_q;
    hold_d  = hold_q;
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_IDLE: begin
        speed_d = '0;
        hold_d  = 1'b1;
      end
      S_RUN: begin
        if (state_q == S_LOAD) speed_d = ent_speed;
        hold_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign speed      = speed_q;
  assign blink_hold = hold_q;
  assign busy       = busy_q;
  assign step_idx   = step_idx_q;
  assign done       = done_q;

endmodule
